// File: rtl/cp0_intc_timer_pkg.sv
// Shared register map and control-bit positions for the CP0 interrupt/timer unit.
package cp0_intc_timer_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_MODE = 5'd16;
  localparam logic [REG_IDX_W-1:0] REG_MASK = 5'd17;
  localparam logic [REG_IDX_W-1:0] REG_PEND = 5'd18;
  localparam logic [REG_IDX_W-1:0] REG_CTRL = 5'd19;

  localparam int CTRL_W    = 2;
  localparam int CTRL_IE   = 0;
  localparam int CTRL_DIV2 = 1;

  function automatic logic [REG_IDX_W-1:0] count_idx(input int n);
    return REG_IDX_W'(2 * n);
  endfunction

  function automatic logic [REG_IDX_W-1:0] compare_idx(input int n);
    return REG_IDX_W'(2 * n + 1);
  endfunction

endpackage

// File: rtl/cp0_cnt_cmp.sv
// One Count/Compare pair with a sticky match flag; writing Compare clears the flag.
module cp0_cnt_cmp #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic             cnt_we,
  input  logic             cmp_we,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] compare,
  output logic             match
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      compare <= '0;
      match   <= 1'b0;
    end else begin
      if (cnt_we)
        count <= wdata;
      else if (inc_en)
        count <= count + 1'b1;

      if (cmp_we)
        compare <= wdata;

      // A Compare write acknowledges the interrupt even if a match lands on the same edge.
      if (cmp_we)
        match <= 1'b0;
      else if ((count == compare) && (compare != '0))
        match <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_intc_timer.sv
// Interrupt/timer unit beside CP0: Count/Compare timers, synchronised external lines with
// per-source edge/level mode, mask, pending and a global enable feeding irq_o.
module cp0_intc_timer
  import cp0_intc_timer_pkg::*;
#(
  parameter int NUM_TIMERS = 2,
  parameter int NUM_HW_INT = 6,
  parameter int CNT_W      = 32,
  parameter int DATA_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [REG_IDX_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]    data_i,
  input  logic [REG_IDX_W-1:0] raddr_i,
  output logic [DATA_W-1:0]    data_o,
  input  logic [NUM_HW_INT-1:0] int_i,
  output logic [NUM_HW_INT-1:0] ip_o,
  output logic [NUM_TIMERS-1:0] timer_int_o,
  output logic                 irq_o
);

  logic [NUM_HW_INT-1:0] mode_q, mask_q, pend_q, pend_nxt;
  logic [NUM_HW_INT-1:0] sync1_q, sync2_q, sync3_q, rise, pending;
  logic [CTRL_W-1:0]     ctrl_q;
  logic                  presc_q, inc_en;
  logic                  wr_mode, wr_mask, wr_pend, wr_ctrl;
  logic [CNT_W-1:0]      count   [NUM_TIMERS];
  logic [CNT_W-1:0]      compare [NUM_TIMERS];

  assign wr_mode = we_i && (waddr_i == REG_MODE);
  assign wr_mask = we_i && (waddr_i == REG_MASK);
  assign wr_pend = we_i && (waddr_i == REG_PEND);
  assign wr_ctrl = we_i && (waddr_i == REG_CTRL);

  // Prescaler idles at 0 while undivided so divided counting always starts on a skip cycle.
  assign inc_en = !ctrl_q[CTRL_DIV2] || presc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      mode_q  <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      ctrl_q  <= '0;
      presc_q <= 1'b0;
    end else begin
      sync1_q <= int_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      presc_q <= ctrl_q[CTRL_DIV2] ? ~presc_q : 1'b0;
      pend_q  <= pend_nxt;
      if (wr_mode) mode_q <= data_i[NUM_HW_INT-1:0];
      if (wr_mask) mask_q <= data_i[NUM_HW_INT-1:0];
      if (wr_ctrl) ctrl_q <= data_i[CTRL_W-1:0];
    end
  end

  assign rise = sync2_q & ~sync3_q;

  // Sticky bits exist only in edge mode; a level-mode bit holds 0 so switching to edge starts clean.
  always_comb begin
    pend_nxt = pend_q;
    for (int i = 0; i < NUM_HW_INT; i++) begin
      if (!mode_q[i])
        pend_nxt[i] = 1'b0;
      else if (rise[i])
        pend_nxt[i] = 1'b1;
      else if (wr_pend && data_i[i])
        pend_nxt[i] = 1'b0;
    end
  end

  assign pending = (mode_q & pend_q) | (~mode_q & sync2_q);

  always_comb begin
    ip_o = pending;
    ip_o[NUM_HW_INT-1] = pending[NUM_HW_INT-1] | (|timer_int_o);
  end

  assign irq_o = (|(ip_o & mask_q)) & ctrl_q[CTRL_IE];

  for (genvar t = 0; t < NUM_TIMERS; t++) begin : g_timer
    cp0_cnt_cmp #(
      .CNT_W(CNT_W)
    ) u_cnt_cmp (
      .clk    (clk),
      .rst    (rst),
      .inc_en (inc_en),
      .cnt_we (we_i && (waddr_i == count_idx(t))),
      .cmp_we (we_i && (waddr_i == compare_idx(t))),
      .wdata  (data_i[CNT_W-1:0]),
      .count  (count[t]),
      .compare(compare[t]),
      .match  (timer_int_o[t])
    );
  end

  always_comb begin
    data_o = '0;
    case (raddr_i)
      REG_MODE: data_o[NUM_HW_INT-1:0] = mode_q;
      REG_MASK: data_o[NUM_HW_INT-1:0] = mask_q;
      REG_PEND: data_o[NUM_HW_INT-1:0] = ip_o;
      REG_CTRL: data_o[CTRL_W-1:0]     = ctrl_q;
      default: begin
        for (int t = 0; t < NUM_TIMERS; t++) begin
          if (raddr_i == count_idx(t))
            data_o[CNT_W-1:0] = count[t];
          else if (raddr_i == compare_idx(t))
            data_o[CNT_W-1:0] = compare[t];
        end
      end
    endcase
  end

endmodule
